// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - steps a frequency/duration note table into the sine generator.
// Optional per-note attack/release envelope is built when NOTESEQ_ENVELOPE_EN is defined.
module note_sequencer #(
  parameter int TICKS_PER_UNIT = 500,
  parameter int ADDR_W         = 6,
  parameter int PEAK_AMPLITUDE = 255,
  parameter int ATTACK_STEP    = 8,
  parameter int RELEASE_TICKS  = 64,
  parameter int RELEASE_STEP   = 4
) (
  input  logic              CLK_32KHz,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] noteAddress,
  input  logic [13:0]       noteFrequency,
  input  logic [7:0]        noteDuration,
  output logic [13:0]       outputFrequency,
  output logic [7:0]        outputAmplitude,
  output logic              noteStrobe,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY} state_t;

  localparam logic [16:0]       TICKS     = 17'(TICKS_PER_UNIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [13:0]       freq_q;
  logic [7:0]        amp_q;
  logic [16:0]       rem_q;
  logic              strobe_q;
  logic              busy_q;
  logic              done_q;

  logic [16:0] load_cnt;
  logic        end_marker;
  logic        last_addr;
  logic        finish;
  logic        go_idle;

  assign load_cnt   = 17'(noteDuration) * TICKS;
  assign end_marker = (noteFrequency == 14'd0) && (noteDuration == 8'd0);
  assign last_addr  = (addr_q == LAST_ADDR);

  // Normal song completion: end marker, or running off the last table address.
  always_comb begin
    finish = 1'b0;
    case (state_q)
      S_FETCH: finish = end_marker || ((noteDuration == 8'd0) && last_addr);
      S_PLAY:  finish = (rem_q == 17'd1) && last_addr;
      default: finish = 1'b0;
    endcase
    go_idle = stop || finish;
  end

`ifdef NOTESEQ_ENVELOPE_EN
  logic       rest_q;
  logic [8:0] amp_up_d;
  logic [7:0] amp_d;

  // 9-bit saturating attack/release; rests never leave zero.
  always_comb begin
    amp_up_d = {1'b0, amp_q} + 9'(ATTACK_STEP);
    amp_d    = 8'd0;
    if (rest_q) begin
      amp_d = 8'd0;
    end else if (rem_q <= 17'(RELEASE_TICKS)) begin
      if ({1'b0, amp_q} > 9'(RELEASE_STEP))
        amp_d = 8'({1'b0, amp_q} - 9'(RELEASE_STEP));
      else
        amp_d = 8'd0;
    end else if (amp_up_d > 9'(PEAK_AMPLITUDE)) begin
      amp_d = 8'(PEAK_AMPLITUDE);
    end else begin
      amp_d = amp_up_d[7:0];
    end
  end
`else
  localparam int unused_env_cfg = ATTACK_STEP + RELEASE_TICKS + RELEASE_STEP;
`endif

  always_ff @(posedge CLK_32KHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      freq_q   <= 14'd0;
      amp_q    <= 8'd0;
      rem_q    <= 17'd0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef NOTESEQ_ENVELOPE_EN
      rest_q   <= 1'b0;
`endif
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      if (go_idle) begin
        state_q <= S_IDLE;
        addr_q  <= '0;
        freq_q  <= 14'd0;
        amp_q   <= 8'd0;
        rem_q   <= 17'd0;
        busy_q  <= 1'b0;
        done_q  <= finish && !stop;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q <= S_FETCH;
              addr_q  <= '0;
              busy_q  <= 1'b1;
            end
          end
          S_FETCH: begin
            if (noteDuration == 8'd0) begin
              addr_q <= addr_q + 1'b1;
            end else begin
              state_q  <= S_PLAY;
              freq_q   <= noteFrequency;
              rem_q    <= load_cnt;
              strobe_q <= 1'b1;
`ifdef NOTESEQ_ENVELOPE_EN
              amp_q    <= 8'd0;
              rest_q   <= (noteFrequency == 14'd0);
`else
              amp_q    <= (noteFrequency == 14'd0) ? 8'd0 : 8'(PEAK_AMPLITUDE);
`endif
            end
          end
          S_PLAY: begin
            rem_q <= rem_q - 17'd1;
`ifdef NOTESEQ_ENVELOPE_EN
            amp_q <= amp_d;
`endif
            if (rem_q == 17'd1) begin
              state_q <= S_FETCH;
              addr_q  <= addr_q + 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign noteAddress     = addr_q;
  assign outputFrequency = freq_q;
  assign outputAmplitude = amp_q;
  assign noteStrobe      = strobe_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer.
// Table vectors, random tables against a trace model, and stop/start/reset sequences.
module tb_note_sequencer;

  localparam int TPU  = 4;
  localparam int AW   = 2;
  localparam int PEAK = 255;
  localparam int AS   = 64;
  localparam int RELT = 2;
  localparam int RS   = 128;
`ifdef NOTESEQ_ENVELOPE_EN
  localparam bit ENV = 1'b1;
`else
  localparam bit ENV = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  addr;
    logic [13:0] freq;
    logic [7:0]  amp;
    logic        strobe;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct {
    logic [3:0][13:0] f;
    logic [3:0][7:0]  d;
    int               lat;
    int               strb;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  note_addr;
  logic [13:0] note_freq;
  logic [7:0]  note_dur;
  logic [13:0] out_freq;
  logic [7:0]  out_amp;
  logic        strobe;
  logic        busy;
  logic        done;

  logic [3:0][13:0] tbl_f = '0;
  logic [3:0][7:0]  tbl_d = '0;

  assign note_freq = tbl_f[note_addr];
  assign note_dur  = tbl_d[note_addr];

  always #5 clk = ~clk;

  note_sequencer #(
    .TICKS_PER_UNIT(TPU), .ADDR_W(AW), .PEAK_AMPLITUDE(PEAK),
    .ATTACK_STEP(AS), .RELEASE_TICKS(RELT), .RELEASE_STEP(RS)
  ) dut (
    .CLK_32KHz(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .noteAddress(note_addr), .noteFrequency(note_freq), .noteDuration(note_dur),
    .outputFrequency(out_freq), .outputAmplitude(out_amp),
    .noteStrobe(strobe), .busy(busy), .done(done)
  );

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  int   obs_amp[64];
  int   obs_freq[64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t mk(input int a, input int f, input int amp,
                              input bit s, input bit b, input bit dn);
    obs_t o;
    o.addr = 2'(a); o.freq = 14'(f); o.amp = 8'(amp);
    o.strobe = s; o.busy = b; o.done = dn;
    return o;
  endfunction

  function automatic obs_t cur();
    return mk(int'(note_addr), int'(out_freq), int'(out_amp), strobe, busy, done);
  endfunction

  task automatic check_obs(input string name, input int idx, input obs_t got, input obs_t e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s cycle %0d: got addr=%0d freq=%0d amp=%0d strb=%0b busy=%0b done=%0b, expected addr=%0d freq=%0d amp=%0d strb=%0b busy=%0b done=%0b",
               name, idx, got.addr, got.freq, got.amp, got.strobe, got.busy, got.done,
               e.addr, e.freq, e.amp, e.strobe, e.busy, e.done);
    end
  endtask

  task automatic check_val(input string name, input int got, input int e);
    checks++;
    if (got != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, e);
    end
  endtask

  // Reference: expected outputs for each cycle after start, from the playback rules.
  task automatic build_trace(input logic [3:0][13:0] tf, input logic [3:0][7:0] td);
    int prev_f;
    int amp;
    int len;
    bit rest;
    bit fin;
    prev_f = 0; amp = 0; fin = 1'b0;
    exp_q.delete();
    for (int a = 0; a < 4 && !fin; a++) begin
      exp_q.push_back(mk(a, prev_f, amp, 1'b0, 1'b1, 1'b0));
      if (tf[a] == 14'd0 && td[a] == 8'd0) begin
        fin = 1'b1;
      end else if (td[a] != 8'd0) begin
        len  = int'(td[a]) * TPU;
        rest = (tf[a] == 14'd0);
        amp  = (ENV || rest) ? 0 : PEAK;
        for (int k = 0; k < len; k++) begin
          exp_q.push_back(mk(a, int'(tf[a]), amp, k == 0, 1'b1, 1'b0));
          if (ENV && !rest) begin
            if (len - k <= RELT) amp = (amp - RS < 0) ? 0 : amp - RS;
            else                 amp = (amp + AS > PEAK) ? PEAK : amp + AS;
          end
        end
        prev_f = int'(tf[a]);
      end
    end
    exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic run_vector(input logic [3:0][13:0] tf, input logic [3:0][7:0] td,
                            output int latency, output int strobes);
    tbl_f = tf;
    tbl_d = td;
    build_trace(tf, td);
    latency = -1;
    strobes = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      if (i < 64) begin
        obs_amp[i]  = int'(out_amp);
        obs_freq[i] = int'(out_freq);
      end
      check_obs("trace", i, cur(), exp_q[i]);
      if (done && latency < 0) latency = i + 1;
      if (strobe) strobes++;
    end
  endtask

  vec_t vecs[5];
  int   env_amps[8];

  initial begin
    int lat;
    int nstr;
    int c;
    int r;
    logic [3:0][13:0] rf;
    logic [3:0][7:0]  rd;

    // {entry3, entry2, entry1, entry0}
    vecs[0].f = {14'd0, 14'd0, 14'd0, 14'd440};    vecs[0].d = {8'd0, 8'd0, 8'd0, 8'd2};
    vecs[0].lat = 11; vecs[0].strb = 1;
    vecs[1].f = {14'd0, 14'd262, 14'd1000, 14'd0}; vecs[1].d = {8'd0, 8'd1, 8'd0, 8'd1};
    vecs[1].lat = 13; vecs[1].strb = 2;
    vecs[2].f = {14'd400, 14'd300, 14'd200, 14'd100}; vecs[2].d = {8'd1, 8'd1, 8'd1, 8'd1};
    vecs[2].lat = 21; vecs[2].strb = 4;
    vecs[3].f = {14'd9, 14'd9, 14'd9, 14'd0};      vecs[3].d = {8'd1, 8'd1, 8'd1, 8'd0};
    vecs[3].lat = 2;  vecs[3].strb = 0;
    vecs[4].f = {14'd8, 14'd7, 14'd6, 14'd5};      vecs[4].d = {8'd0, 8'd0, 8'd0, 8'd0};
    vecs[4].lat = 5;  vecs[4].strb = 0;
    if (ENV) env_amps = '{0, 64, 128, 192, 255, 255, 255, 127};
    else     env_amps = '{255, 255, 255, 255, 255, 255, 255, 255};

    reset_n = 1'b0;
    tick(); tick();
    check_obs("reset", 0, cur(), mk(0, 0, 0, 1'b0, 1'b0, 1'b0));
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      run_vector(vecs[v].f, vecs[v].d, lat, nstr);
      check_val($sformatf("vec%0d_done_latency", v), lat, vecs[v].lat);
      check_val($sformatf("vec%0d_strobes", v), nstr, vecs[v].strb);
      if (v == 0) begin
        for (int i = 0; i < 8; i++) begin
          check_val($sformatf("note1_amp[%0d]", i), obs_amp[i + 1], env_amps[i]);
          check_val($sformatf("note1_freq[%0d]", i), obs_freq[i + 1], 440);
        end
      end
    end

    for (int t = 0; t < 25; t++) begin
      for (int e = 0; e < 4; e++) begin
        r = int'($urandom_range(0, 5));
        case (r)
          0:       begin rf[e] = 14'd0; rd[e] = 8'd0; end
          1:       begin rf[e] = 14'($urandom_range(1, 16383)); rd[e] = 8'd0; end
          2:       begin rf[e] = 14'd0; rd[e] = 8'($urandom_range(1, 3)); end
          default: begin rf[e] = 14'($urandom_range(1, 16383)); rd[e] = 8'($urandom_range(1, 3)); end
        endcase
      end
      run_vector(rf, rd, lat, nstr);
    end

    // stop in the third PLAY cycle
    tbl_f = vecs[0].f; tbl_d = vecs[0].d;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check_obs("stop_pre", 0, cur(), mk(0, 440, env_amps[2], 1'b0, 1'b1, 1'b0));
    stop = 1'b1; tick(); stop = 1'b0;
    check_obs("stop_idle", 0, cur(), mk(0, 0, 0, 1'b0, 1'b0, 1'b0));
    tick();
    check_obs("stop_no_done", 1, cur(), mk(0, 0, 0, 1'b0, 1'b0, 1'b0));

    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check_obs("start_stop", 0, cur(), mk(0, 0, 0, 1'b0, 1'b0, 1'b0));
    tick();
    check_obs("start_stop", 1, cur(), mk(0, 0, 0, 1'b0, 1'b0, 1'b0));

    // start re-asserted while busy must not restart the song
    start = 1'b1; tick(); start = 1'b0;
    c = 1; lat = -1; nstr = 0;
    while (c < 40 && lat < 0) begin
      start = (c >= 2 && c <= 6);
      tick();
      c++;
      if (strobe) nstr++;
      if (done) lat = c;
    end
    start = 1'b0;
    check_val("busy_start_latency", lat, 11);
    check_val("busy_start_strobes", nstr, 1);
    tick();

    // asynchronous reset in mid-PLAY
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check_val("reset_pre_busy", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1 check_obs("async_reset", 0, cur(), mk(0, 0, 0, 1'b0, 1'b0, 1'b0));
    tick();
    check_obs("reset_hold", 1, cur(), mk(0, 0, 0, 1'b0, 1'b0, 1'b0));
    reset_n = 1'b1;
    tick();
    run_vector(vecs[0].f, vecs[0].d, lat, nstr);
    check_val("replay_latency", lat, 11);
    check_val("replay_strobes", nstr, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Upstream driver for the sine signal generator. Steps through an external note table of frequency/duration pairs and drives the generator's frequency input. It shapes a per-note amplitude envelope for the generator's amplitude input. Start/stop control and a done pulse let the mode controller play a song and detect its end.

## Interface
- `TICKS_PER_UNIT`, default 500: CLK_32KHz cycles per duration unit (500 = 1/64 s).
- `ADDR_W`, default 6: note table address width; table depth = 2^ADDR_W.
- `PEAK_AMPLITUDE`, default 255: sustain amplitude.
- `ATTACK_STEP`, default 8: amplitude increment per PLAY cycle.
- `RELEASE_TICKS`, default 64: release window length in cycles at note end.
- `RELEASE_STEP`, default 4: amplitude decrement per release cycle.

Ports:
- `CLK_32KHz` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin playback at address 0; honoured only in IDLE.
- `stop` in 1: abort playback; honoured in any state.
- `noteAddress` out ADDR_W: table read address.
- `noteFrequency` in 14: table frequency in Hz, combinational from `noteAddress`. 0 marks a rest.
- `noteDuration` in 8: table duration in units.
- `outputFrequency` out 14: drives the generator frequency input.
- `outputAmplitude` out 8: drives the generator amplitude input.
- `noteStrobe` out 1: one-cycle pulse in the first PLAY cycle of each entry.
- `busy` out 1: high in FETCH and PLAY.
- `done` out 1: one-cycle pulse on normal song completion.

## Operation
States:
- **IDLE**
  - `start` moves to FETCH with `noteAddress`=0.
- **FETCH**, one cycle; samples the table entry.
  - Entry (0,0) is the end marker: go to IDLE.
  - Entry with duration 0 and frequency ≠0 is skipped: address+1, stay in FETCH, no strobe.
  - Otherwise:
    - load `outputFrequency` = `noteFrequency`;
    - load the remaining counter = `noteDuration`×`TICKS_PER_UNIT`;
    - load amplitude per the envelope rule;
    - go to PLAY.
- **PLAY**
  - Remaining counter decrements each cycle.
  - When the counter is 1 in a cycle, the next state is FETCH at address+1.
  - If the address was 2^ADDR_W−1, the next state is IDLE instead; the address does not wrap.
- Remaining counter width: 17 bits (255×500 = 127500).
- Rest entry (frequency 0, duration ≠0): `outputFrequency`=0 and `outputAmplitude`=0 for the full duration. `noteStrobe` still pulses.
- Entering IDLE by normal completion (end marker or last address): `done`=1 for the first IDLE cycle.
- On every entry to IDLE: `outputFrequency`=0, `outputAmplitude`=0, `noteAddress`=0.
- `stop`: next state is IDLE regardless of current state; `done` is not pulsed.
  - `stop` and `start` in the same cycle: `stop` wins.
- `start` while busy is ignored.
- Outputs hold their values through the inter-note FETCH cycle.

## Timing
- Reset values: state IDLE; `noteAddress` 0; `outputFrequency` 0; `outputAmplitude` 0; `noteStrobe` 0; `busy` 0; `done` 0.
- `start` sampled high at cycle N: FETCH at N+1, first PLAY cycle at N+2.
- New `outputFrequency` and `noteStrobe` are valid in the first PLAY cycle.
- Each played entry occupies D×TICKS_PER_UNIT PLAY cycles plus 1 FETCH cycle. Each skipped entry costs 1 FETCH cycle.
- End marker seen in FETCH at cycle M: `done`=1 and `busy`=0 at M+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `NOTESEQ_ENVELOPE_EN` defined:
  - FETCH loads amplitude 0.
  - Each PLAY cycle, with remaining counter R and amplitude A, computes the next amplitude:
    - if R ≤ RELEASE_TICKS: next = max(A−RELEASE_STEP, 0);
    - otherwise: next = min(A+ATTACK_STEP, PEAK_AMPLITUDE).
  - Arithmetic is done in 9 bits, saturating.
  - Rests stay at 0.
- `NOTESEQ_ENVELOPE_EN` undefined:
  - FETCH loads `PEAK_AMPLITUDE`, or 0 for a rest.
  - Amplitude is constant through PLAY.
  - The envelope logic is absent.

## Test plan
Bench parameters: TICKS_PER_UNIT=4, ADDR_W=2, PEAK_AMPLITUDE=255, ATTACK_STEP=64, RELEASE_TICKS=2, RELEASE_STEP=128.

1. Table {(440,2),(0,0)}, `start` at N, envelope on:
   - `noteStrobe` at N+2;
   - `outputFrequency`=440 for N+2..N+9;
   - `outputAmplitude` sequence 0,64,128,192,255,255,255,127;
   - `done` at N+11, then frequency and amplitude 0.
2. Same table, envelope off: `outputAmplitude`=255 for N+2..N+9; `done` at N+11.
3. Table {(0,1),(1000,0),(262,1),(0,0)}:
   - rest: freq 0, amp 0, 4 cycles, with strobe;
   - address 1 skipped in one FETCH cycle with no strobe;
   - 262 Hz plays 4 cycles;
   - `done` follows.
4. Four 1-unit notes, no end marker: all four play; `done` after address 3; `noteAddress` returns to 0 with no wrap.
5. `stop` during the 3rd PLAY cycle:
   - IDLE next cycle, outputs 0, no `done`;
   - `start`+`stop` in the same cycle stays IDLE;
   - `start` while busy is ignored.
6. `reset_n` low mid-PLAY: all outputs 0 asynchronously. After release, a new `start` replays from address 0.
